// File: rtl/req_debounce_pkg.sv
// Shared constants, types and width helpers for the request-line debouncer.
// Modules derive their own widths from their parameters through the helper functions.
package req_debounce_pkg;

    localparam int DB_WIDTH        = 12;
    localparam int DB_TICK_DIV     = 100000;
    localparam int DB_STABLE_TICKS = 20;

    localparam int DB_CNT_W = $clog2(DB_STABLE_TICKS + 1);
    localparam int DB_DIV_W = $clog2(DB_TICK_DIV);

    typedef enum logic [1:0] {
        DB_EV_NONE,
        DB_EV_PRESS,
        DB_EV_RELEASE
    } db_event_e;

    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    // A TICK_DIV of exactly 2 would give a 1-bit counter; never let it collapse to 0 bits.
    function automatic int div_width(input int tick_div);
        return (tick_div < 2) ? 1 : $clog2(tick_div);
    endfunction

    // Active-low lines: settling to 0 is a press, settling to 1 is a release.
    function automatic db_event_e edge_event(input logic new_level);
        return new_level ? DB_EV_RELEASE : DB_EV_PRESS;
    endfunction

endpackage

// File: rtl/req_debounce_cell.sv
// One debounced request bit: stability counter, registered level and edge pulses.
// The next-state level is exported so the top can register any_active in step with req_db.
module db_cell
    import req_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DB_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_bit,
    input  logic tick,
    output logic level,
    output logic level_next,
    output logic press,
    output logic release_pulse
);

    localparam int               CNT_W    = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    db_event_e        event_d;

    // Any sample matching the accepted level restarts qualification from zero.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        event_d   = DB_EV_NONE;
        if (sync_bit == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                level_d = sync_bit;
                event_d = edge_event(sync_bit);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d   = (event_d == DB_EV_PRESS);
        release_d = (event_d == DB_EV_RELEASE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            level_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level         = level_q;
    assign level_next    = level_d;
    assign press         = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/req_debounce.sv
// Debouncer for the active-low request switches: two-flop synchroniser, shared tick prescaler,
// one db_cell per line. The release pulse port is release_pulse since "release" is a keyword.
module req_debounce
    import req_debounce_pkg::*;
#(
    parameter int WIDTH        = DB_WIDTH,
    parameter int TICK_DIV     = DB_TICK_DIV,
    parameter int STABLE_TICKS = DB_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_raw,
    output logic [WIDTH-1:0] req_db,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic             any_active
);

    localparam int               DIV_W    = div_width(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [WIDTH-1:0] req_db_d;
    logic             any_active_q, any_active_d;

    // Synchroniser resets to all ones so no line looks pressed coming out of reset.
    always_comb begin
        sync1_d = req_raw;
        sync2_d = sync1_q;
    end

    // Free-running prescaler; input activity never restarts it.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    always_comb begin
        any_active_d = |(~req_db_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            div_q        <= '0;
            any_active_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            div_q        <= div_d;
            any_active_q <= any_active_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        db_cell #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_cell (
            .clk          (clk),
            .rst_n        (rst_n),
            .sync_bit     (sync2_q[i]),
            .tick         (tick),
            .level        (req_db[i]),
            .level_next   (req_db_d[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i])
        );
    end

    assign any_active = any_active_q;

endmodule

// File: tb/tb_req_debounce.sv
// Directed bench for req_debounce with TICK_DIV=4, STABLE_TICKS=3: a change is accepted
// 11..14 clock edges after the raw line moves (2 sync edges plus 9..12 qualification cycles).
module tb_req_debounce;

    localparam int W  = 12;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int LAT_MIN = 11;
    localparam int LAT_MAX = 14;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] req_raw;
    logic [W-1:0] req_db;
    logic [W-1:0] press;
    logic [W-1:0] release_pulse;
    logic         any_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_debounce #(
        .WIDTH       (W),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_raw      (req_raw),
        .req_db       (req_db),
        .press        (press),
        .release_pulse(release_pulse),
        .any_active   (any_active)
    );

    // Counts edges until req_db leaves old_db; lat = -1 if it never does within 40 cycles.
    task automatic wait_db_change(input logic [W-1:0] old_db, output int lat,
                                  output logic [W-1:0] early);
        lat   = -1;
        early = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (req_db !== old_db) begin
                lat = n;
                break;
            end
            early |= press | release_pulse;
        end
    endtask

    task automatic test_reset();
        int           lat;
        logic [W-1:0] early;
        rst_n   = 1'b0;
        req_raw = 12'h000;
        repeat (3) @(negedge clk);
        checks++;
        if (req_db !== 12'hFFF) begin errors++; $display("[TB] FAIL reset_req_db: got %h expected %h", req_db, 12'hFFF); end
        checks++;
        if (press !== 12'h000) begin errors++; $display("[TB] FAIL reset_press: got %h expected %h", press, 12'h000); end
        checks++;
        if (release_pulse !== 12'h000) begin errors++; $display("[TB] FAIL reset_release: got %h expected %h", release_pulse, 12'h000); end
        checks++;
        if (any_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_any_active: got %b expected 0", any_active); end
        rst_n = 1'b1;
        wait_db_change(12'hFFF, lat, early);
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("[TB] FAIL reset_held_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++;
        if (req_db !== 12'h000) begin errors++; $display("[TB] FAIL reset_held_req_db: got %h expected %h", req_db, 12'h000); end
        checks++;
        if (press !== 12'hFFF) begin errors++; $display("[TB] FAIL reset_held_press: got %h expected %h", press, 12'hFFF); end
        checks++;
        if (release_pulse !== 12'h000) begin errors++; $display("[TB] FAIL reset_held_release: got %h expected %h", release_pulse, 12'h000); end
        checks++;
        if (any_active !== 1'b1) begin errors++; $display("[TB] FAIL reset_held_any_active: got %b expected 1", any_active); end
        checks++;
        if (early !== 12'h000) begin errors++; $display("[TB] FAIL reset_held_early_pulse: got %h expected %h", early, 12'h000); end
        @(posedge clk);
        #1;
        checks++;
        if (press !== 12'h000) begin errors++; $display("[TB] FAIL reset_held_press_width: got %h expected %h", press, 12'h000); end
    endtask

    task automatic test_release_all();
        int           lat;
        logic [W-1:0] early;
        @(negedge clk);
        req_raw = 12'hFFF;
        wait_db_change(12'h000, lat, early);
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("[TB] FAIL release_all_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++;
        if (req_db !== 12'hFFF) begin errors++; $display("[TB] FAIL release_all_req_db: got %h expected %h", req_db, 12'hFFF); end
        checks++;
        if (release_pulse !== 12'hFFF) begin errors++; $display("[TB] FAIL release_all_release: got %h expected %h", release_pulse, 12'hFFF); end
        checks++;
        if (press !== 12'h000) begin errors++; $display("[TB] FAIL release_all_press: got %h expected %h", press, 12'h000); end
        checks++;
        if (any_active !== 1'b0) begin errors++; $display("[TB] FAIL release_all_any_active: got %b expected 0", any_active); end
        @(posedge clk);
        #1;
        checks++;
        if (release_pulse !== 12'h000) begin errors++; $display("[TB] FAIL release_all_width: got %h expected %h", release_pulse, 12'h000); end
    endtask

    task automatic test_clean_press();
        int           lat;
        logic [W-1:0] early;
        @(negedge clk);
        req_raw = 12'hFFE;
        wait_db_change(12'hFFF, lat, early);
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("[TB] FAIL clean_press_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++;
        if (req_db !== 12'hFFE) begin errors++; $display("[TB] FAIL clean_press_req_db: got %h expected %h", req_db, 12'hFFE); end
        checks++;
        if (press !== 12'h001) begin errors++; $display("[TB] FAIL clean_press_press: got %h expected %h", press, 12'h001); end
        checks++;
        if (release_pulse !== 12'h000) begin errors++; $display("[TB] FAIL clean_press_release: got %h expected %h", release_pulse, 12'h000); end
        checks++;
        if (any_active !== 1'b1) begin errors++; $display("[TB] FAIL clean_press_any_active: got %b expected 1", any_active); end
        checks++;
        if (early !== 12'h000) begin errors++; $display("[TB] FAIL clean_press_early_pulse: got %h expected %h", early, 12'h000); end
        @(posedge clk);
        #1;
        checks++;
        if (press !== 12'h000) begin errors++; $display("[TB] FAIL clean_press_width: got %h expected %h", press, 12'h000); end
        @(negedge clk);
        req_raw = 12'hFFF;
        wait_db_change(12'hFFE, lat, early);
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("[TB] FAIL clean_release_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++;
        if (release_pulse !== 12'h001) begin errors++; $display("[TB] FAIL clean_release_release: got %h expected %h", release_pulse, 12'h001); end
        checks++;
        if (press !== 12'h000) begin errors++; $display("[TB] FAIL clean_release_press: got %h expected %h", press, 12'h000); end
        checks++;
        if (any_active !== 1'b0) begin errors++; $display("[TB] FAIL clean_release_any_active: got %b expected 0", any_active); end
        @(posedge clk);
        #1;
        checks++;
        if (release_pulse !== 12'h000) begin errors++; $display("[TB] FAIL clean_release_width: got %h expected %h", release_pulse, 12'h000); end
    endtask

    task automatic test_bounce();
        int           lat;
        logic [W-1:0] early;
        logic [W-1:0] seen = '0;
        logic [W-1:0] db_low = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            seen   |= press | release_pulse;
            db_low |= ~req_db;
            if (k % 3 == 0) req_raw[5] = ~req_raw[5];
        end
        @(negedge clk);
        seen   |= press | release_pulse;
        db_low |= ~req_db;
        req_raw[5] = 1'b0;
        checks++;
        if (seen !== 12'h000) begin errors++; $display("[TB] FAIL bounce_pulses: got %h expected %h", seen, 12'h000); end
        checks++;
        if (db_low !== 12'h000) begin errors++; $display("[TB] FAIL bounce_req_db_low: got %h expected %h", db_low, 12'h000); end
        wait_db_change(12'hFFF, lat, early);
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("[TB] FAIL bounce_settle_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++;
        if (req_db !== 12'hFDF) begin errors++; $display("[TB] FAIL bounce_req_db: got %h expected %h", req_db, 12'hFDF); end
        checks++;
        if (press !== 12'h020) begin errors++; $display("[TB] FAIL bounce_press: got %h expected %h", press, 12'h020); end
        checks++;
        if (early !== 12'h000) begin errors++; $display("[TB] FAIL bounce_early_pulse: got %h expected %h", early, 12'h000); end
        @(posedge clk);
        #1;
        checks++;
        if (press !== 12'h000) begin errors++; $display("[TB] FAIL bounce_press_width: got %h expected %h", press, 12'h000); end
        @(negedge clk);
        req_raw[5] = 1'b1;
        wait_db_change(12'hFDF, lat, early);
        checks++;
        if (release_pulse !== 12'h020) begin errors++; $display("[TB] FAIL bounce_release: got %h expected %h", release_pulse, 12'h020); end
    endtask

    task automatic test_glitch();
        logic [W-1:0] seen = '0;
        logic [W-1:0] db_low = '0;
        logic         act = 1'b0;
        @(negedge clk);
        req_raw[11] = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            seen   |= press | release_pulse;
            db_low |= ~req_db;
            act    |= any_active;
            if (k == 5) req_raw[11] = 1'b1;
        end
        checks++;
        if (db_low !== 12'h000) begin errors++; $display("[TB] FAIL glitch_req_db_low: got %h expected %h", db_low, 12'h000); end
        checks++;
        if (seen !== 12'h000) begin errors++; $display("[TB] FAIL glitch_pulses: got %h expected %h", seen, 12'h000); end
        checks++;
        if (act !== 1'b0) begin errors++; $display("[TB] FAIL glitch_any_active: got %b expected 0", act); end
    endtask

    task automatic test_simultaneous();
        int           lat;
        logic [W-1:0] early;
        @(negedge clk);
        req_raw = 12'h5A5;
        wait_db_change(12'hFFF, lat, early);
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("[TB] FAIL simult_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++;
        if (req_db !== 12'h5A5) begin errors++; $display("[TB] FAIL simult_req_db: got %h expected %h", req_db, 12'h5A5); end
        checks++;
        if (press !== 12'hA5A) begin errors++; $display("[TB] FAIL simult_press: got %h expected %h", press, 12'hA5A); end
        checks++;
        if (release_pulse !== 12'h000) begin errors++; $display("[TB] FAIL simult_release: got %h expected %h", release_pulse, 12'h000); end
        checks++;
        if (any_active !== 1'b1) begin errors++; $display("[TB] FAIL simult_any_active: got %b expected 1", any_active); end
        @(posedge clk);
        #1;
        checks++;
        if (press !== 12'h000 || req_db !== 12'h5A5) begin errors++; $display("[TB] FAIL simult_hold: got press %h req_db %h expected press 000 req_db 5a5", press, req_db); end
        @(negedge clk);
        req_raw = 12'hFFF;
        wait_db_change(12'h5A5, lat, early);
        checks++;
        if (req_db !== 12'hFFF) begin errors++; $display("[TB] FAIL simult_restore_req_db: got %h expected %h", req_db, 12'hFFF); end
        checks++;
        if (release_pulse !== 12'hA5A) begin errors++; $display("[TB] FAIL simult_restore_release: got %h expected %h", release_pulse, 12'hA5A); end
        checks++;
        if (any_active !== 1'b0) begin errors++; $display("[TB] FAIL simult_restore_any_active: got %b expected 0", any_active); end
    endtask

    task automatic test_reset_mid_window();
        int           lat;
        logic [W-1:0] early;
        @(negedge clk);
        req_raw = 12'hFF7;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (req_db !== 12'hFFF) begin errors++; $display("[TB] FAIL midreset_before: got %h expected %h", req_db, 12'hFFF); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (req_db !== 12'hFFF || press !== 12'h000) begin errors++; $display("[TB] FAIL midreset_in_reset: got req_db %h press %h expected fff 000", req_db, press); end
        rst_n = 1'b1;
        wait_db_change(12'hFFF, lat, early);
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("[TB] FAIL midreset_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++;
        if (req_db !== 12'hFF7) begin errors++; $display("[TB] FAIL midreset_req_db: got %h expected %h", req_db, 12'hFF7); end
        checks++;
        if (press !== 12'h008) begin errors++; $display("[TB] FAIL midreset_press: got %h expected %h", press, 12'h008); end
        checks++;
        if (early !== 12'h000) begin errors++; $display("[TB] FAIL midreset_early_pulse: got %h expected %h", early, 12'h000); end
    endtask

    initial begin
        test_reset();
        test_release_all();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
